// File: rtl/noc_config_sequencer.sv
// In-order configuration-word sequencer for the 2x2 mesh: queues {dest, word}
// commands and drives each word onto one pN_configure port for a fixed hold time.
module noc_config_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_dest,
  input  logic [10:0] cmd_word,
  input  logic [3:0]  processor_ready_signals,
  output logic [10:0] p0_configure,
  output logic [10:0] p1_configure,
  output logic [10:0] p2_configure,
  output logic [10:0] p3_configure,
  output logic        issue_done,
  output logic        dropped,
  output logic        busy
);

  localparam int unsigned WORD_W  = 11;
  localparam int unsigned DEST_W  = 2;
  localparam int unsigned ENTRY_W = WORD_W + DEST_W;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned TMR_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [3:0][WORD_W-1:0]  cfg_q, cfg_d;
  logic                    issue_done_q, issue_done_d;
  logic                    dropped_q, dropped_d;
  logic                    busy_q, busy_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ENTRY_W-1:0]      mem [DEPTH];

  logic                    full_c;
  logic                    empty_c;
  logic                    push_c;
  logic                    pop_c;
  logic [ENTRY_W-1:0]      head_c;
  logic [DEST_W-1:0]       head_dest_c;
  logic [WORD_W-1:0]       head_word_c;

  assign full_c      = (count_q == CNT_W'(DEPTH));
  assign empty_c     = (count_q == '0);
  assign cmd_ready   = !full_c;
  assign push_c      = cmd_valid && !full_c;
  assign head_c      = mem[rd_ptr_q];
  assign head_dest_c = head_c[ENTRY_W-1:WORD_W];
  assign head_word_c = head_c[WORD_W-1:0];

  // Sequencer FSM: issue, hold, then enforce the inter-word gap.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    cfg_d        = cfg_q;
    issue_done_d = 1'b0;
    dropped_d    = 1'b0;
    pop_c        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          if (head_word_c == '0) begin
            pop_c     = 1'b1;
            dropped_d = 1'b1;
          end else if (processor_ready_signals[head_dest_c]) begin
            pop_c              = 1'b1;
            cfg_d[head_dest_c] = head_word_c;
            tmr_d              = TMR_W'(HOLD_CYCLES - 1);
            state_d            = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        if (tmr_q == '0) begin
          cfg_d        = '0;
          issue_done_d = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            tmr_d   = TMR_W'(GAP_CYCLES - 1);
            state_d = ST_GAP;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Queue pointer/occupancy update; busy is registered from next-state values so it has no lag.
  always_comb begin
    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    busy_d   = (count_d != '0) || (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (push_c) begin
      mem[wr_ptr_q] <= {cmd_dest, cmd_word};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      cfg_q        <= '0;
      issue_done_q <= 1'b0;
      dropped_q    <= 1'b0;
      busy_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      cfg_q        <= cfg_d;
      issue_done_q <= issue_done_d;
      dropped_q    <= dropped_d;
      busy_q       <= busy_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign p0_configure = cfg_q[0];
  assign p1_configure = cfg_q[1];
  assign p2_configure = cfg_q[2];
  assign p3_configure = cfg_q[3];
  assign issue_done   = issue_done_q;
  assign dropped      = dropped_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_noc_config_sequencer.sv
// Randomized plus directed bench for noc_config_sequencer against a
// timeline-based reference model of the command queue and issue schedule.
module tb_noc_config_sequencer;

  localparam int DEPTH = 4;
  localparam int H     = 4;
  localparam int G     = 2;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_dest;
  logic [10:0] cmd_word;
  logic [3:0]  processor_ready_signals;
  logic [10:0] p0_configure, p1_configure, p2_configure, p3_configure;
  logic        issue_done, dropped, busy;

  noc_config_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dest(cmd_dest),
    .cmd_word(cmd_word),
    .processor_ready_signals(processor_ready_signals),
    .p0_configure(p0_configure),
    .p1_configure(p1_configure),
    .p2_configure(p2_configure),
    .p3_configure(p3_configure),
    .issue_done(issue_done),
    .dropped(dropped),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Reference model: edge counter, pending commands, and the issue timeline.
  int          n       = 0;
  logic [12:0] q[$];
  int          next_ok = 0;
  int          act_t   = -1000;
  int          act_dest = 0;
  logic [10:0] act_word = '0;
  int          drop_n  = -1;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, n);
  endtask

  task automatic model_step();
    int          sz0;
    logic [12:0] h;
    n++;
    if (reset) begin
      q.delete();
      next_ok = n + 1;
      act_t   = -1000;
      drop_n  = -1;
      return;
    end
    sz0 = q.size();
    if (n >= next_ok && sz0 > 0) begin
      h = q[0];
      if (h[10:0] == 11'd0) begin
        void'(q.pop_front());
        drop_n  = n;
        next_ok = n + 1;
      end else if (processor_ready_signals[h[12:11]]) begin
        void'(q.pop_front());
        act_t    = n;
        act_dest = int'(h[12:11]);
        act_word = h[10:0];
        next_ok  = n + H + G + 1;
      end
    end
    if (cmd_valid && sz0 < DEPTH) q.push_back({cmd_dest, cmd_word});
  endtask

  function automatic logic [10:0] exp_cfg(input int d);
    if (act_t >= 0 && n >= act_t && n < act_t + H && d == act_dest) return act_word;
    return 11'd0;
  endfunction

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      check("p0_configure", 16'(p0_configure), 16'(exp_cfg(0)));
      check("p1_configure", 16'(p1_configure), 16'(exp_cfg(1)));
      check("p2_configure", 16'(p2_configure), 16'(exp_cfg(2)));
      check("p3_configure", 16'(p3_configure), 16'(exp_cfg(3)));
      check("issue_done", 16'(issue_done), 16'(act_t >= 0 && n == act_t + H));
      check("dropped", 16'(dropped), 16'(drop_n == n));
      check("busy", 16'(busy), 16'(q.size() != 0 || n + 1 < next_ok));
      check("cmd_ready", 16'(cmd_ready), 16'(q.size() < DEPTH));
    end
  end

  task automatic step_edges(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] d, input logic [10:0] w);
    cmd_valid = 1'b1;
    cmd_dest  = d;
    cmd_word  = w;
    step_edges(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      step_edges(1);
    end
    check(name, 16'(busy), 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_dest = '0;
    cmd_word = '0;
    processor_ready_signals = 4'hF;
    step_edges(2);
    check("rst_p0", 16'(p0_configure), 16'd0);
    check("rst_p3", 16'(p3_configure), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_cmd_ready", 16'(cmd_ready), 16'd1);
    check("rst_issue_done", 16'(issue_done), 16'd0);
    reset = 1'b0;
    step_edges(2);

    // Single issue followed by a back-to-back command to another port.
    push_cmd(2'd2, 11'b01000000011);
    push_cmd(2'd3, 11'h201);
    check("single_first_cycle", 16'(p2_configure), 16'h203);
    step_edges(3);
    check("single_last_cycle", 16'(p2_configure), 16'h203);
    check("single_done_early", 16'(issue_done), 16'd0);
    step_edges(1);
    check("single_cleared", 16'(p2_configure), 16'd0);
    check("single_done", 16'(issue_done), 16'd1);
    step_edges(2);
    check("b2b_not_yet", 16'(p3_configure), 16'd0);
    step_edges(1);
    check("b2b_issue", 16'(p3_configure), 16'h201);
    check("b2b_no_overlap", 16'(p2_configure), 16'd0);
    wait_idle("idle_after_b2b");

    // Ready stall on dest 3.
    processor_ready_signals = 4'b0111;
    push_cmd(2'd3, 11'h155);
    step_edges(3);
    check("stall_p3", 16'(p3_configure), 16'd0);
    check("stall_busy", 16'(busy), 16'd1);
    processor_ready_signals = 4'b1111;
    step_edges(1);
    check("stall_release", 16'(p3_configure), 16'h155);
    wait_idle("idle_after_stall");

    // Full queue: fifth push must be refused.
    processor_ready_signals = 4'b0000;
    for (int i = 0; i < 4; i++) push_cmd(2'(i), 11'(16 * i + 7));
    check("full_cmd_ready", 16'(cmd_ready), 16'd0);
    push_cmd(2'd1, 11'h7FF);
    check("full_still", 16'(cmd_ready), 16'd0);
    processor_ready_signals = 4'b1111;
    step_edges(1);
    check("full_first_out", 16'(p0_configure), 16'd7);
    wait_idle("idle_after_full");

    // Zero word is dropped, following word issues.
    push_cmd(2'd1, 11'd0);
    push_cmd(2'd1, 11'h0FF);
    check("drop_pulse", 16'(dropped), 16'd1);
    check("drop_not_driven", 16'(p1_configure), 16'd0);
    step_edges(1);
    check("drop_next_word", 16'(p1_configure), 16'h0FF);
    check("drop_once", 16'(dropped), 16'd0);
    wait_idle("idle_after_drop");

    // Reset during the second hold cycle with two commands queued.
    push_cmd(2'd0, 11'h3AA);
    push_cmd(2'd1, 11'h111);
    push_cmd(2'd2, 11'h222);
    check("pre_reset_hold", 16'(p0_configure), 16'h3AA);
    reset = 1'b1;
    #1;
    check("async_rst_p0", 16'(p0_configure), 16'd0);
    check("async_rst_busy", 16'(busy), 16'd0);
    step_edges(1);
    reset = 1'b0;
    step_edges(10);
    check("post_rst_busy", 16'(busy), 16'd0);
    check("post_rst_ready", 16'(cmd_ready), 16'd1);
    check("post_rst_p1", 16'(p1_configure), 16'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_dest  = 2'($urandom_range(0, 3));
      cmd_word  = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
      if ($urandom_range(0, 3) == 0) processor_ready_signals = 4'($urandom_range(0, 15));
      step_edges(1);
    end
    cmd_valid = 1'b0;
    processor_ready_signals = 4'hF;
    wait_idle("final_drain");
    step_edges(2);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, check_cnt);
    $fatal(1);
  end

endmodule
